// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port between NREQ producers.
// A grant lasts until the producer drops req or BURST words have been written.
//
// state | meaning
// IDLE  | no grant; scan req from ptr and grant the first requester found
// GRANT | grant_id owns the FIFO write port; stalls while fifofull is high
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic                  fifofull,
  output logic                  fifo_we,
  output logic [WIDTH-1:0]      fifo_din,
  output logic [NREQ-1:0]       ack,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  localparam int CW = (BURST > 1) ? $clog2(BURST + 1) : 1;
  localparam logic [CW-1:0]  LAST  = CW'(BURST - 1);
  localparam logic [IDW-1:0] MAXID = IDW'(NREQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  next_id;
  logic [IDW-1:0]  ptr_next;
  logic            found;
  logic            write;
  int              scan_idx;
  logic [WIDTH-1:0] words [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words[i] = data[i*WIDTH +: WIDTH];
    end
  end

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    next_id  = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && req[IDW'(scan_idx)]) begin
        found   = 1'b1;
        next_id = IDW'(scan_idx);
      end
    end
  end

  assign ptr_next = (grant_id == MAXID) ? '0 : grant_id + 1'b1;
  assign busy     = (state == GRANT);
  assign write    = busy & req[grant_id] & ~fifofull;
  assign fifo_we  = write;
  assign ack      = write ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id) : '0;
  assign fifo_din = busy ? words[grant_id] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= next_id;
            cnt      <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (write) cnt <= cnt + 1'b1;
          // A withdrawn request or the last beat of a burst both hand the port back.
          if (!req[grant_id] || (write && cnt == LAST)) begin
            state <= IDLE;
            ptr   <= ptr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
